// File: rtl/tx_retry_tracker_pkg.sv
// Shared constants and types for the TX read-request tracker / retry engine.
package tx_retry_tracker_pkg;

    // Format/type field of a completion-with-data header (fmt=10, type=01010)
    localparam logic [6:0] CPL_W_DATA_FMT_TYPE = 7'b10_01010;

    // Completion status codes
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;
    localparam logic [2:0] CPL_STATUS_CA = 3'b100;

    // rd_error_code values
    localparam logic [1:0] RD_ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] RD_ERR_LENGTH  = 2'b01;
    localparam logic [1:0] RD_ERR_STATUS  = 2'b10;

    // Monitor (scan/retry) FSM states
    typedef enum logic [2:0] {
        MON_SCAN     = 3'd0,
        MON_CHECK    = 3'd1,
        MON_ISSUE    = 3'd2,
        MON_WAIT_ACK = 3'd3,
        MON_HOLD     = 3'd4
    } mon_state_t;

    // UR and CA both mean "the completer gave up, ask again"
    function automatic logic is_retry_status(input logic [2:0] status);
        return (status == CPL_STATUS_UR) || (status == CPL_STATUS_CA);
    endfunction

endpackage

// File: rtl/tx_retry_tracker_cpl_decode.sv
// Snoops the RX TRN stream and turns each completion-with-data header into a
// one-cycle {valid, tag, len, status} strobe. Header QW0 carries length and
// status, QW1 (the next valid beat) carries the tag.
module tx_retry_cpl_decode
    import tx_retry_tracker_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             trn_clk,
    input  logic             reset,
    input  logic [63:0]      trn_rd,
    input  logic             trn_rsof_n,
    input  logic             trn_rsrc_rdy_n,
    input  logic             trn_rdst_rdy_n,
    output logic             cpl_valid,
    output logic [TAG_W-1:0] cpl_tag,
    output logic [9:0]       cpl_len,
    output logic [2:0]       cpl_status
);

    logic       beat;
    logic       hdr_seen;
    logic [9:0] hdr_len;
    logic [2:0] hdr_status;
    logic       unused_rd;

    assign beat = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;

    // Payload bits outside the decoded fields are deliberately ignored
    assign unused_rd = ^trn_rd;

    // Capture the first header beat, then emit the strobe on the tag beat
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            hdr_seen   <= 1'b0;
            hdr_len    <= '0;
            hdr_status <= '0;
            cpl_valid  <= 1'b0;
            cpl_tag    <= '0;
            cpl_len    <= '0;
            cpl_status <= '0;
        end else begin
            cpl_valid <= 1'b0;
            if (beat) begin
                if (!trn_rsof_n) begin
                    hdr_seen   <= (trn_rd[62:56] == CPL_W_DATA_FMT_TYPE);
                    hdr_len    <= trn_rd[41:32];
                    hdr_status <= trn_rd[15:13];
                end else if (hdr_seen) begin
                    hdr_seen   <= 1'b0;
                    cpl_valid  <= 1'b1;
                    cpl_tag    <= trn_rd[40+TAG_W-1:40];
                    cpl_len    <= hdr_len;
                    cpl_status <= hdr_status;
                end
            end
        end
    end

endmodule

// File: rtl/tx_retry_tracker.sv
// Tracks outstanding host-memory reads per tag, advances them on completions,
// and re-issues the remainder on timeout or UR/CA until MAX_RETRIES is used up.
module tx_retry_tracker
    import tx_retry_tracker_pkg::*;
#(
    parameter int NUM_TAGS       = 8,
    parameter int TAG_W          = 3,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                trn_clk,
    input  logic                reset,
    input  logic [63:0]         trn_rd,
    input  logic                trn_rsof_n,
    input  logic                trn_rsrc_rdy_n,
    input  logic                trn_rdst_rdy_n,
    input  logic                read_chunk,
    input  logic                read_chunk_ack,
    input  logic [TAG_W-1:0]    tlp_tag,
    input  logic [63:0]         huge_page_addr_read_from,
    input  logic [8:0]          qwords_to_rd,
    output logic [NUM_TAGS-1:0] tag_pending,
    output logic                retry_read_chunk,
    input  logic                retry_read_chunk_ack,
    output logic [TAG_W-1:0]    retry_tlp_tag,
    output logic [63:0]         retry_huge_page_addr_read_from,
    output logic [9:0]          retry_dwords_to_rd,
    output logic                rd_error,
    output logic [TAG_W-1:0]    rd_error_tag,
    output logic [1:0]          rd_error_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [63:0]         ent_addr    [NUM_TAGS];
    logic [9:0]          ent_rem     [NUM_TAGS];
    logic [3:0]          ent_retries [NUM_TAGS];
    logic [NUM_TAGS-1:0] ent_retry_now;
    logic [NUM_TAGS-1:0] tag_expired;
    logic [NUM_TAGS-1:0] cnt_clr;
    logic [NUM_TAGS-1:0] entry_drop;

    logic             dec_valid;
    logic [TAG_W-1:0] dec_tag;
    logic [9:0]       dec_len;
    logic [2:0]       dec_status;

    logic             cpl_p_valid;
    logic [TAG_W-1:0] cpl_p_tag;
    logic [9:0]       cpl_p_len;
    logic [2:0]       cpl_p_status;

    logic reg_fire, cpl_ok, cpl_ovf, cpl_adv, cpl_rty, ack_fire, exhaust_fire, expire_now;

    mon_state_t       state;
    logic [TAG_W-1:0] scan_ptr;
    logic [TAG_W-1:0] cur_tag;

    tx_retry_cpl_decode #(.TAG_W(TAG_W)) u_cpl_decode (
        .trn_clk        (trn_clk),
        .reset          (reset),
        .trn_rd         (trn_rd),
        .trn_rsof_n     (trn_rsof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rdst_rdy_n (trn_rdst_rdy_n),
        .cpl_valid      (dec_valid),
        .cpl_tag        (dec_tag),
        .cpl_len        (dec_len),
        .cpl_status     (dec_status)
    );

    // Second completion pipeline stage so the entry update lands two cycles after the tag beat
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            cpl_p_valid  <= 1'b0;
            cpl_p_tag    <= '0;
            cpl_p_len    <= '0;
            cpl_p_status <= '0;
        end else begin
            cpl_p_valid  <= dec_valid;
            cpl_p_tag    <= dec_tag;
            cpl_p_len    <= dec_len;
            cpl_p_status <= dec_status;
        end
    end

    assign reg_fire   = read_chunk && read_chunk_ack;
    // A registration on the same tag in the same cycle overrides the completion
    assign cpl_ok     = cpl_p_valid && tag_pending[cpl_p_tag] && !(reg_fire && tlp_tag == cpl_p_tag);
    assign cpl_ovf    = cpl_ok && (cpl_p_status == CPL_STATUS_SC) && (cpl_p_len > ent_rem[cpl_p_tag]);
    assign cpl_adv    = cpl_ok && (cpl_p_status == CPL_STATUS_SC) && !cpl_ovf;
    assign cpl_rty    = cpl_ok && is_retry_status(cpl_p_status);
    assign ack_fire   = (state == MON_WAIT_ACK) && retry_read_chunk_ack;
    assign expire_now = tag_expired[cur_tag] || ent_retry_now[cur_tag];
    assign exhaust_fire = (state == MON_CHECK) && tag_pending[cur_tag] && expire_now && !cpl_ovf
                          && (ent_retries[cur_tag] == 4'(MAX_RETRIES));

    // Per-tag events that restart the idle counter or abandon the entry
    always_comb begin
        cnt_clr    = '0;
        entry_drop = '0;
        if (reg_fire)             cnt_clr[tlp_tag]       = 1'b1;
        if (cpl_adv || cpl_ovf)   cnt_clr[cpl_p_tag]     = 1'b1;
        if (ack_fire)             cnt_clr[retry_tlp_tag] = 1'b1;
        if (exhaust_fire)         cnt_clr[cur_tag]       = 1'b1;
        if (cpl_ovf)              entry_drop[cpl_p_tag]  = 1'b1;
        if (exhaust_fire)         entry_drop[cur_tag]    = 1'b1;
    end

    // Saturating idle counter per tag, running only while the tag is pending
    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tmo
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge trn_clk or posedge reset) begin
            if (reset)
                cnt <= '0;
            else if (cnt_clr[g])
                cnt <= '0;
            else if (tag_pending[g] && cnt != CNT_W'(TIMEOUT_CYCLES))
                cnt <= cnt + 1'b1;
        end
        assign tag_expired[g] = (cnt == CNT_W'(TIMEOUT_CYCLES));
    end

    // Entry table: registration first, then abandonment, then progress/retry bookkeeping
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            tag_pending   <= '0;
            ent_retry_now <= '0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                ent_addr[t]    <= '0;
                ent_rem[t]     <= '0;
                ent_retries[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (reg_fire && tlp_tag == TAG_W'(t)) begin
                    ent_addr[t]      <= huge_page_addr_read_from;
                    ent_rem[t]       <= {qwords_to_rd, 1'b0};
                    ent_retries[t]   <= '0;
                    ent_retry_now[t] <= 1'b0;
                    tag_pending[t]   <= 1'b1;
                end else if (entry_drop[t]) begin
                    tag_pending[t]   <= 1'b0;
                    ent_retry_now[t] <= 1'b0;
                    ent_retries[t]   <= '0;
                end else begin
                    if (cpl_adv && cpl_p_tag == TAG_W'(t)) begin
                        ent_addr[t] <= ent_addr[t] + {52'd0, cpl_p_len, 2'b00};
                        ent_rem[t]  <= ent_rem[t] - cpl_p_len;
                        if (ent_rem[t] == cpl_p_len)
                            tag_pending[t] <= 1'b0;
                    end
                    if (ack_fire && retry_tlp_tag == TAG_W'(t))
                        ent_retries[t] <= ent_retries[t] + 4'd1;
                    if (cpl_rty && cpl_p_tag == TAG_W'(t))
                        ent_retry_now[t] <= 1'b1;
                    else if (ack_fire && retry_tlp_tag == TAG_W'(t))
                        ent_retry_now[t] <= 1'b0;
                end
            end
        end
    end

    // Monitor FSM: round-robin scan, timeout check, retry issue and error reporting
    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state                          <= MON_SCAN;
            scan_ptr                       <= '0;
            cur_tag                        <= '0;
            retry_read_chunk               <= 1'b0;
            retry_tlp_tag                  <= '0;
            retry_huge_page_addr_read_from <= '0;
            retry_dwords_to_rd             <= '0;
            rd_error                       <= 1'b0;
            rd_error_tag                   <= '0;
            rd_error_code                  <= '0;
        end else begin
            rd_error <= 1'b0;
            if (cpl_ovf) begin
                rd_error      <= 1'b1;
                rd_error_tag  <= cpl_p_tag;
                rd_error_code <= RD_ERR_LENGTH;
            end
            case (state)
                MON_SCAN: begin
                    scan_ptr <= scan_ptr + 1'b1;
                    if (tag_pending[scan_ptr]) begin
                        cur_tag <= scan_ptr;
                        state   <= MON_CHECK;
                    end
                end
                MON_CHECK: begin
                    if (!tag_pending[cur_tag] || !expire_now) begin
                        state <= MON_SCAN;
                    end else if (cpl_ovf) begin
                        state <= MON_CHECK;
                    end else if (ent_retries[cur_tag] == 4'(MAX_RETRIES)) begin
                        rd_error      <= 1'b1;
                        rd_error_tag  <= cur_tag;
                        rd_error_code <= ent_retry_now[cur_tag] ? RD_ERR_STATUS : RD_ERR_TIMEOUT;
                        state         <= MON_SCAN;
                    end else begin
                        state <= MON_ISSUE;
                    end
                end
                MON_ISSUE: begin
                    if (!tag_pending[cur_tag]) begin
                        state <= MON_SCAN;
                    end else begin
                        retry_read_chunk               <= 1'b1;
                        retry_tlp_tag                  <= cur_tag;
                        retry_huge_page_addr_read_from <= ent_addr[cur_tag];
                        retry_dwords_to_rd             <= ent_rem[cur_tag];
                        state                          <= MON_WAIT_ACK;
                    end
                end
                MON_WAIT_ACK: begin
                    if (retry_read_chunk_ack) begin
                        retry_read_chunk <= 1'b0;
                        state            <= MON_HOLD;
                    end
                end
                MON_HOLD: state <= MON_SCAN;
                default:  state <= MON_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_retry_tracker.sv
// Scoreboard bench for tx_retry_tracker: directed requests/completions push the
// expected retries and errors, a monitor pops and compares them as they appear.
module tb_tx_retry_tracker;

    localparam int NUM_TAGS = 8;
    localparam int TAG_W    = 3;
    localparam int TIMEOUT  = 8192;
    localparam int KIND_REG = 0;
    localparam int KIND_CPL = 1;
    localparam logic [2:0] ST_SC = 3'b000;
    localparam logic [2:0] ST_UR = 3'b001;

    logic                trn_clk;
    logic                reset;
    logic [63:0]         trn_rd;
    logic                trn_rsof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n;
    logic                read_chunk, read_chunk_ack;
    logic [TAG_W-1:0]    tlp_tag;
    logic [63:0]         huge_page_addr_read_from;
    logic [8:0]          qwords_to_rd;
    logic [NUM_TAGS-1:0] tag_pending;
    logic                retry_read_chunk;
    logic                retry_read_chunk_ack;
    logic [TAG_W-1:0]    retry_tlp_tag;
    logic [63:0]         retry_huge_page_addr_read_from;
    logic [9:0]          retry_dwords_to_rd;
    logic                rd_error;
    logic [TAG_W-1:0]    rd_error_tag;
    logic [1:0]          rd_error_code;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      addr;
        logic [9:0]       dw;
    } retry_exp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       code;
    } err_exp_t;

    retry_exp_t retry_q[$];
    err_exp_t   err_q[$];
    int total = 0;
    int bad   = 0;
    logic ack_enable = 1'b1;

    tx_retry_tracker #(
        .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(3)
    ) dut (
        .trn_clk                        (trn_clk),
        .reset                          (reset),
        .trn_rd                         (trn_rd),
        .trn_rsof_n                     (trn_rsof_n),
        .trn_rsrc_rdy_n                 (trn_rsrc_rdy_n),
        .trn_rdst_rdy_n                 (trn_rdst_rdy_n),
        .read_chunk                     (read_chunk),
        .read_chunk_ack                 (read_chunk_ack),
        .tlp_tag                        (tlp_tag),
        .huge_page_addr_read_from       (huge_page_addr_read_from),
        .qwords_to_rd                   (qwords_to_rd),
        .tag_pending                    (tag_pending),
        .retry_read_chunk               (retry_read_chunk),
        .retry_read_chunk_ack           (retry_read_chunk_ack),
        .retry_tlp_tag                  (retry_tlp_tag),
        .retry_huge_page_addr_read_from (retry_huge_page_addr_read_from),
        .retry_dwords_to_rd             (retry_dwords_to_rd),
        .rd_error                       (rd_error),
        .rd_error_tag                   (rd_error_tag),
        .rd_error_code                  (rd_error_code)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // kind REG: len = QW count; kind CPL: two-beat completion header
    task automatic applyStimulus(input int kind, input logic [TAG_W-1:0] tag, input logic [63:0] addr,
                                 input logic [9:0] len, input logic [2:0] status);
        if (kind == KIND_REG) begin
            @(negedge trn_clk);
            read_chunk = 1'b1;
            read_chunk_ack = 1'b1;
            tlp_tag = tag;
            huge_page_addr_read_from = addr;
            qwords_to_rd = len[8:0];
            @(negedge trn_clk);
            read_chunk = 1'b0;
            read_chunk_ack = 1'b0;
        end else begin
            @(negedge trn_clk);
            trn_rd = 64'h0;
            trn_rd[62:56] = 7'b10_01010;
            trn_rd[41:32] = len;
            trn_rd[15:13] = status;
            trn_rsof_n = 1'b0;
            trn_rsrc_rdy_n = 1'b0;
            trn_rdst_rdy_n = 1'b0;
            @(negedge trn_clk);
            trn_rd = 64'h0;
            trn_rd[40+TAG_W-1:40] = tag;
            trn_rsof_n = 1'b1;
            @(negedge trn_clk);
            trn_rd = 64'h0;
            trn_rsrc_rdy_n = 1'b1;
            trn_rdst_rdy_n = 1'b1;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge trn_clk);
    endtask

    task automatic waitQueuesEmpty(input string name, input int budget);
        int n = 0;
        while ((retry_q.size() != 0 || err_q.size() != 0) && n < budget) begin
            @(negedge trn_clk);
            n++;
        end
        total++;
        if (retry_q.size() != 0 || err_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s: %0d retries and %0d errors still outstanding after %0d cycles, required 0",
                     name, retry_q.size(), err_q.size(), budget);
        end
    endtask

    task automatic waitRetryLevel(input string name, input logic level, input int budget);
        int n = 0;
        while (retry_read_chunk !== level && n < budget) begin
            @(negedge trn_clk);
            n++;
        end
        checkOutput(name, 64'(retry_read_chunk), 64'(level));
    endtask

    // Retry acceptor: acknowledges each retry three cycles after it appears
    initial begin
        int ack_wait = 0;
        retry_read_chunk_ack = 1'b0;
        forever begin
            @(negedge trn_clk);
            if (ack_enable && retry_read_chunk && !reset) begin
                ack_wait++;
                retry_read_chunk_ack = (ack_wait == 3);
            end else begin
                ack_wait = 0;
                retry_read_chunk_ack = 1'b0;
            end
        end
    end

    // Monitor: compare every new retry request and every error pulse against the scoreboard
    initial begin
        logic prev_retry = 1'b0;
        retry_exp_t r;
        err_exp_t   e;
        forever begin
            @(negedge trn_clk);
            if (reset) begin
                prev_retry = 1'b0;
            end else begin
                if (retry_read_chunk && !prev_retry) begin
                    if (retry_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_retry: got retry for tag %0d, expected none", retry_tlp_tag);
                    end else begin
                        r = retry_q.pop_front();
                        checkOutput("retry_tag",  64'(retry_tlp_tag), 64'(r.tag));
                        checkOutput("retry_addr", retry_huge_page_addr_read_from, r.addr);
                        checkOutput("retry_dw",   64'(retry_dwords_to_rd), 64'(r.dw));
                    end
                end
                prev_retry = retry_read_chunk;
                if (rd_error) begin
                    if (err_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_error: got error tag %0d code %0d, expected none",
                                 rd_error_tag, rd_error_code);
                    end else begin
                        e = err_q.pop_front();
                        checkOutput("err_tag",  64'(rd_error_tag), 64'(e.tag));
                        checkOutput("err_code", 64'(rd_error_code), 64'(e.code));
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        reset = 1'b1;
        trn_rd = 64'h0;
        trn_rsof_n = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rdst_rdy_n = 1'b1;
        read_chunk = 1'b0;
        read_chunk_ack = 1'b0;
        tlp_tag = '0;
        huge_page_addr_read_from = 64'h0;
        qwords_to_rd = 9'd0;
        waitCycles(3);
        checkOutput("rst_pending", 64'(tag_pending), 64'h0);
        checkOutput("rst_retry",   64'(retry_read_chunk), 64'h0);
        checkOutput("rst_error",   64'(rd_error), 64'h0);
        checkOutput("rst_dw",      64'(retry_dwords_to_rd), 64'h0);
        reset = 1'b0;
        waitCycles(2);

        // Request without acceptance must not register
        @(negedge trn_clk);
        read_chunk = 1'b1;
        tlp_tag = 3'd7;
        qwords_to_rd = 9'd4;
        @(negedge trn_clk);
        read_chunk = 1'b0;
        checkOutput("no_ack_no_reg", 64'(tag_pending), 64'h0);

        $display("[TB] tag 2 completes normally");
        applyStimulus(KIND_REG, 3'd2, 64'h1000, 10'd16, ST_SC);
        checkOutput("t2_pending", 64'(tag_pending), 64'h04);
        applyStimulus(KIND_CPL, 3'd2, 64'h0, 10'd16, ST_SC);
        waitCycles(4);
        checkOutput("t2_half", 64'(tag_pending), 64'h04);
        applyStimulus(KIND_CPL, 3'd2, 64'h0, 10'd16, ST_SC);
        waitCycles(4);
        checkOutput("t2_done", 64'(tag_pending), 64'h00);

        $display("[TB] tag 5 partial completion then timeout");
        applyStimulus(KIND_REG, 3'd5, 64'h0000_0001_0000_4000, 10'd8, ST_SC);
        applyStimulus(KIND_CPL, 3'd5, 64'h0, 10'd4, ST_SC);
        retry_q.push_back('{tag: 3'd5, addr: 64'h0000_0001_0000_4010, dw: 10'd12});
        waitQueuesEmpty("t5_retry", TIMEOUT + 64);
        waitRetryLevel("t5_acked", 1'b0, 20);
        applyStimulus(KIND_CPL, 3'd5, 64'h0, 10'd12, ST_SC);
        waitCycles(4);
        checkOutput("t5_done", 64'(tag_pending), 64'h00);

        $display("[TB] tag 1 never answered");
        applyStimulus(KIND_REG, 3'd1, 64'h8000, 10'd4, ST_SC);
        for (int i = 0; i < 3; i++)
            retry_q.push_back('{tag: 3'd1, addr: 64'h8000, dw: 10'd8});
        err_q.push_back('{tag: 3'd1, code: 2'b00});
        waitQueuesEmpty("t1_exhaust", 4 * (TIMEOUT + 64));
        waitCycles(2);
        checkOutput("t1_cleared", 64'(tag_pending), 64'h00);

        $display("[TB] tag 3 UR completion");
        applyStimulus(KIND_REG, 3'd3, 64'h3000, 10'd10, ST_SC);
        retry_q.push_back('{tag: 3'd3, addr: 64'h3000, dw: 10'd20});
        applyStimulus(KIND_CPL, 3'd3, 64'h0, 10'd20, ST_UR);
        lat = 0;
        while (!retry_read_chunk && lat < 40) begin
            @(negedge trn_clk);
            lat++;
        end
        total++;
        if (!retry_read_chunk || lat > NUM_TAGS + 3 + 2) begin
            bad++;
            $display("[TB] FAIL t3_latency: got %0d cycles, required <= %0d", lat, NUM_TAGS + 5);
        end
        waitRetryLevel("t3_acked", 1'b0, 20);
        applyStimulus(KIND_CPL, 3'd3, 64'h0, 10'd20, ST_SC);
        waitCycles(4);
        checkOutput("t3_done", 64'(tag_pending), 64'h00);

        $display("[TB] tag 6 length overflow");
        applyStimulus(KIND_REG, 3'd6, 64'h6000, 10'd2, ST_SC);
        err_q.push_back('{tag: 3'd6, code: 2'b01});
        applyStimulus(KIND_CPL, 3'd6, 64'h0, 10'd8, ST_SC);
        waitQueuesEmpty("t6_overflow", 20);
        checkOutput("t6_cleared", 64'(tag_pending), 64'h00);

        $display("[TB] reset while retry outstanding");
        ack_enable = 1'b0;
        applyStimulus(KIND_REG, 3'd4, 64'h4000, 10'd1, ST_SC);
        retry_q.push_back('{tag: 3'd4, addr: 64'h4000, dw: 10'd2});
        applyStimulus(KIND_CPL, 3'd4, 64'h0, 10'd2, ST_UR);
        waitRetryLevel("t4_retry_up", 1'b1, 40);
        waitCycles(3);
        checkOutput("t4_retry_held", 64'(retry_read_chunk), 64'h1);
        checkOutput("t4_tag_held",   64'(retry_tlp_tag), 64'h4);
        reset = 1'b1;
        #1;
        checkOutput("t4_rst_retry", 64'(retry_read_chunk), 64'h0);
        @(negedge trn_clk);
        checkOutput("t4_rst_pending", 64'(tag_pending), 64'h0);
        checkOutput("t4_rst_tag",     64'(retry_tlp_tag), 64'h0);
        checkOutput("t4_rst_addr",    retry_huge_page_addr_read_from, 64'h0);
        checkOutput("t4_rst_dw",      64'(retry_dwords_to_rd), 64'h0);
        checkOutput("t4_rst_errtag",  64'(rd_error_tag), 64'h0);
        reset = 1'b0;
        ack_enable = 1'b1;
        waitCycles(20);
        checkOutput("t4_quiet_retry",   64'(retry_read_chunk), 64'h0);
        checkOutput("t4_quiet_pending", 64'(tag_pending), 64'h0);
        checkOutput("final_retry_q", 64'(retry_q.size()), 64'h0);
        checkOutput("final_err_q",   64'(err_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
